seg_scan_ctrl: RTL

Time-multiplexing scan controller for the 4-digit common-anode seven-segment display. Cycles a digit index at a programmable refresh rate, drives the active-low anode lines and the 4-bit nibble for the hex-to-segment decoder, and applies new 16-bit display values only at frame boundaries so a digit never shows a torn value. Sits between the user datapath (value source) and the segment decoder / board pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/refresh_prescaler.sv | 40 ++++
 rtl/seg_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg_pkg                                                     |
// | Description : Shared types and constants for the 4-digit seven-segment    |
// |               scan controller (digit index, hex nibble, anode patterns).  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] hex_t;

    // Anodes are active-low: all ones turns every digit off.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Active-low one-cold anode pattern selecting a single digit.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/refresh_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : refresh_prescaler                                           |
// | Description : Free-running divider producing a one-cycle tick every       |
// |               CLK_DIV clocks. Shared by display refresh, LED and          |
// |               debounce timing.                                            |
// | Ports       : clk  - system clock                                         |
// |               rst  - synchronous active-high reset                        |
// |               tick - high for the last cycle of each CLK_DIV period       |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module refresh_prescaler #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // At least one bit so CLK_DIV=1 still elaborates; the counter then sits
    // at zero and tick is high every cycle.
    localparam int               CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == c_last);

endmodule : refresh_prescaler
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg_scan_ctrl                                               |
// | Description : Time-multiplexed scan controller for a 4-digit common-anode |
// |               seven-segment display. New values are staged in a pending   |
// |               register and only become visible at a frame boundary, so a  |
// |               frame never mixes digits of two different values.           |
// | Ports       : clk, rst   - clock, synchronous active-high reset           |
// |               value_in   - four hex nibbles, [3:0] is the rightmost digit |
// |               load       - capture value_in into the pending register     |
// |               digit_en   - live per-digit enable (0 blanks the digit)     |
// |               an         - active-low anodes                              |
// |               nibble     - hex value of the scanned digit                 |
// |               digit_sel  - current scan index                             |
// |               busy       - a pending value awaits the frame boundary      |
// |               load_ack   - one-cycle pulse after a pending value is shown |
// | Options     : SEG_LZ_BLANK_EN - when defined, leading zeros (digits 3..1) |
// |               are suppressed; digit 0 always shows.                       |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      value_in,
    input  logic             load,
    input  logic [3:0]       digit_en,
    output logic [3:0]       an,
    output hex_t             nibble,
    output digit_idx_t       digit_sel,
    output logic             busy,
    output logic             load_ack
);

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_apply;
    logic [NUM_DIGITS-1:0] w_lz_blank;

    digit_idx_t            r_sel;
    logic [15:0]           r_shown;
    logic [15:0]           r_pending;
    logic                  r_pend_v;
    logic                  r_load_ack;

    refresh_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // The frame ends on the tick that leaves the last digit slot.
    assign w_boundary = w_tick && (r_sel == digit_idx_t'(NUM_DIGITS - 1));
    assign w_apply    = w_boundary && r_pend_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= '0;
            r_shown    <= '0;
            r_pending  <= '0;
            r_pend_v   <= 1'b0;
            r_load_ack <= 1'b0;
        end else begin
            if (w_tick) begin
                r_sel <= r_sel + digit_idx_t'(1);
            end

            r_load_ack <= w_apply;

            if (w_apply) begin
                r_shown  <= r_pending;
                r_pend_v <= 1'b0;
            end

            // Placed after the apply so a load on the boundary cycle re-arms
            // the pending slot with the new value while the old one is shown.
            if (load) begin
                r_pending <= value_in;
                r_pend_v  <= 1'b1;
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Digit k is a leading zero when it and every more significant nibble
    // are zero.
    assign w_lz_blank[0] = 1'b0;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz_blank
        assign w_lz_blank[k] = (r_shown[15:4*k] == '0);
    end
`else
    assign w_lz_blank = '0;
`endif

    assign nibble    = r_shown[{r_sel, 2'b00} +: 4];
    assign an        = (digit_en[r_sel] && !w_lz_blank[r_sel]) ? anode_sel(r_sel)
                                                               : ANODE_OFF;
    assign digit_sel = r_sel;
    assign busy      = r_pend_v;
    assign load_ack  = r_load_ack;

endmodule : seg_scan_ctrl
`default_nettype wire
